// File: rtl/data_mem_responder.sv
// Handshaked multi-cycle byte-addressable data RAM for the MEM stage, returning RV32I-formatted load data.
// Optional build macro: DMEM_MISALIGN_TRAP_EN (misaligned H/W accesses report RespErr instead of aligning).
module data_mem_responder #(
  parameter int DATA_WIDTH        = 32,
  parameter int MEM_ADDRESS_WIDTH = 9,
  parameter int LATENCY           = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ReqValid,
  input  logic                         ReadEnable,
  input  logic                         WriteEnable,
  input  logic [MEM_ADDRESS_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0]        WRData,
  input  logic [2:0]                   Funct3,
  output logic                         ReqReady,
  output logic                         Busy,
  output logic                         RespValid,
  output logic                         RespErr,
  output logic [DATA_WIDTH-1:0]        RDData
);

  localparam int WORDS = 2 ** (MEM_ADDRESS_WIDTH - 2);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                       state;
  logic [3:0]                   cnt;
  logic [MEM_ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]        wdata_q;
  logic [2:0]                   f3_q;
  logic                         wr_q;

  logic [DATA_WIDTH-1:0] mem [WORDS];

  logic [MEM_ADDRESS_WIDTH-1:0] src_addr;
  logic [DATA_WIDTH-1:0]        src_wd;
  logic [2:0]                   src_f3;
  logic                         src_wr;
  logic [1:0]                   size;
  logic [1:0]                   lane;
  logic                         illegal;
  logic                         err_c;
  logic [DATA_WIDTH-1:0]        word;
  logic [DATA_WIDTH-1:0]        shifted;
  logic [DATA_WIDTH-1:0]        ld_c;
  logic [3:0]                   be_c;
  logic [DATA_WIDTH-1:0]        wword_c;

  logic accept;
  assign accept = ReqValid && (ReadEnable || WriteEnable);
  assign Busy   = ReqValid && !RespValid;

  // With LATENCY==1 the response is formed on the accept edge, so decode straight from the inputs while idle.
  always_comb begin
    if (state == S_IDLE) begin
      src_addr = Address;
      src_wd   = WRData;
      src_f3   = Funct3;
      src_wr   = WriteEnable;
    end else begin
      src_addr = addr_q;
      src_wd   = wdata_q;
      src_f3   = f3_q;
      src_wr   = wr_q;
    end
  end

  always_comb begin
    size = src_f3[1:0];
    if (src_wr) illegal = (src_f3 >= 3'd3);
    else        illegal = (src_f3 == 3'd3) || (src_f3[2:1] == 2'b11);
`ifdef DMEM_MISALIGN_TRAP_EN
    err_c = illegal || (size == 2'd1 && src_addr[0]) ||
            (size == 2'd2 && src_addr[1:0] != 2'b00);
    lane  = src_addr[1:0];
`else
    err_c = illegal;
    case (size)
      2'd1:    lane = {src_addr[1], 1'b0};
      2'd2:    lane = 2'b00;
      default: lane = src_addr[1:0];
    endcase
`endif
    word    = mem[src_addr[MEM_ADDRESS_WIDTH-1:2]];
    shifted = word >> {lane, 3'b000};
    case (src_f3)
      3'b000:  ld_c = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ld_c = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  ld_c = shifted;
      3'b100:  ld_c = {24'd0, shifted[7:0]};
      3'b101:  ld_c = {16'd0, shifted[15:0]};
      default: ld_c = '0;
    endcase
    if (err_c) ld_c = '0;
    case (size)
      2'd0: begin
        be_c    = 4'b0001 << lane;
        wword_c = {4{src_wd[7:0]}};
      end
      2'd1: begin
        be_c    = 4'b0011 << lane;
        wword_c = {2{src_wd[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wword_c = src_wd;
      end
    endcase
  end

  // Store commits on the edge leaving RESP, so a reset during WAIT or RESP drops it.
  always_ff @(posedge clk) begin
    if (state == S_RESP && wr_q && !err_c) begin
      for (int b = 0; b < 4; b++) begin
        if (be_c[b]) mem[addr_q[MEM_ADDRESS_WIDTH-1:2]][8*b +: 8] <= wword_c[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      f3_q      <= '0;
      wr_q      <= 1'b0;
      ReqReady  <= 1'b1;
      RespValid <= 1'b0;
      RespErr   <= 1'b0;
      RDData    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            addr_q   <= Address;
            wdata_q  <= WRData;
            f3_q     <= Funct3;
            wr_q     <= WriteEnable;
            cnt      <= 4'(LATENCY - 1);
            ReqReady <= 1'b0;
            if (LATENCY == 1) begin
              state     <= S_RESP;
              RespValid <= 1'b1;
              RespErr   <= err_c;
              if (!src_wr || err_c) RDData <= ld_c;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state     <= S_RESP;
            RespValid <= 1'b1;
            RespErr   <= err_c;
            if (!src_wr || err_c) RDData <= ld_c;
          end
        end
        S_RESP: begin
          state     <= S_IDLE;
          RespValid <= 1'b0;
          ReqReady  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
